// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter.
// Holds the FSM state enum, index width and one-hot decode helper.
package mem_bus_arbiter_pkg;

  // Sized for the largest supported requester count, so one
  // pointer width serves every NREQ in 2..4.
  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = $clog2(NREQ_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [NREQ_MAX-1:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < NREQ_MAX; i++)
      if (oh[i]) oh2idx = IDX_W'(i);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Ports: req (vector), ptr (start index) -> pick (one-hot), valid.
module rr_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   prot;

  // Rotate so ptr lands at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into place.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    prot  = rot & (-rot);
    back  = {prot, prot} << ptr;
    pick  = back[2*N-1:N];
    valid = |req;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among NREQ cache clients.
// Ports: per-client arb/bus channels (cli_*), memory side (bus_*).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int GRANT_TIMEOUT  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               cli_abtr_reqcyc,
  input  logic [NREQ-1:0]               cli_bus_busy,
  output logic [NREQ-1:0]               cli_abtr_grant,
  input  logic [NREQ-1:0]               cli_bus_reqcyc,
  input  logic [NREQ*BUS_DATA_WIDTH-1:0] cli_bus_req,
  input  logic [NREQ*BUS_TAG_WIDTH-1:0] cli_bus_reqtag,
  input  logic [NREQ-1:0]               cli_bus_respack,
  output logic [NREQ-1:0]               cli_bus_reqack,
  output logic [NREQ-1:0]               cli_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]     cli_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]      cli_bus_resptag,
  output logic                          bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]     bus_req,
  output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
  output logic                          bus_respack,
  input  logic                          bus_reqack,
  input  logic                          bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag
);

  localparam int CW = $clog2(GRANT_TIMEOUT + 1);

  arb_state_t       state;
  logic [NREQ-1:0]  grant_q;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CW-1:0]    cnt;

  logic [NREQ-1:0]     pick;
  logic                pick_valid;
  logic [NREQ_MAX-1:0] pick_pad;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    owner_nxt;
  logic [IDX_W-1:0]    ptr_sel;
  logic                own;
  logic                own_busy;
  logic                own_req;

  assign own      = |grant_q;
  assign own_busy = |(cli_bus_busy & grant_q);
  assign own_req  = |(cli_abtr_reqcyc & grant_q);

  assign owner_nxt = (owner == IDX_W'(NREQ - 1))
                   ? '0 : owner + IDX_W'(1);

  // In RELEASE the picker already looks from owner+1, so a
  // pending client is regranted straight after the turnaround.
  assign ptr_sel  = (state == RELEASE) ? owner_nxt : rr_ptr;
  assign pick_pad = NREQ_MAX'(pick);
  assign pick_idx = oh2idx(pick_pad);

  rr_picker #(.N(NREQ)) u_pick (
    .req   (cli_abtr_reqcyc),
    .ptr   (ptr_sel),
    .pick  (pick),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE, RELEASE: begin
          if (state == RELEASE) rr_ptr <= owner_nxt;
          if (pick_valid) begin
            state   <= GRANTED;
            grant_q <= pick;
            owner   <= pick_idx;
            cnt     <= '0;
          end else begin
            state   <= IDLE;
          end
        end
        GRANTED: begin
          // cnt counts granted cycles already spent; the grant
          // is held for exactly GRANT_TIMEOUT cycles without busy.
          if (own_busy) begin
            state <= OWNED;
          end else if (!own_req ||
                       cnt == CW'(GRANT_TIMEOUT - 1)) begin
            state   <= RELEASE;
            grant_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OWNED: begin
          if (!own_busy) begin
            state   <= RELEASE;
            grant_q <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign cli_abtr_grant = grant_q;

  // grant_q is zero in IDLE and RELEASE, so masking with it
  // forces every routed signal low whenever nobody owns the bus.
  always_comb begin
    bus_req    = '0;
    bus_reqtag = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        bus_req    = bus_req |
          cli_bus_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        bus_reqtag = bus_reqtag |
          cli_bus_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
      end
    end
  end

  assign bus_reqcyc      = |(cli_bus_reqcyc & grant_q);
  assign bus_respack     = |(cli_bus_respack & grant_q);
  assign cli_bus_reqack  = grant_q & {NREQ{bus_reqack}};
  assign cli_bus_respcyc = grant_q & {NREQ{bus_respcyc}};
  assign cli_bus_resp    = own ? bus_resp : '0;
  assign cli_bus_resptag = own ? bus_resptag : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant_q))
        else $error("grant vector not one-hot");
      assert (!(bus_respcyc && !own))
        else $error("memory response with no owner dropped");
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter.
// Expectations are queued at drive time and popped at observation.
module tb_mem_bus_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 64;
  localparam int TW   = 13;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      cli_abtr_reqcyc;
  logic [NREQ-1:0]      cli_bus_busy;
  logic [NREQ-1:0]      cli_abtr_grant;
  logic [NREQ-1:0]      cli_bus_reqcyc;
  logic [NREQ*DW-1:0]   cli_bus_req;
  logic [NREQ*TW-1:0]   cli_bus_reqtag;
  logic [NREQ-1:0]      cli_bus_respack;
  logic [NREQ-1:0]      cli_bus_reqack;
  logic [NREQ-1:0]      cli_bus_respcyc;
  logic [DW-1:0]        cli_bus_resp;
  logic [TW-1:0]        cli_bus_resptag;
  logic                 bus_reqcyc;
  logic [DW-1:0]        bus_req;
  logic [TW-1:0]        bus_reqtag;
  logic                 bus_respack;
  logic                 bus_reqack;
  logic                 bus_respcyc;
  logic [DW-1:0]        bus_resp;
  logic [TW-1:0]        bus_resptag;

  mem_bus_arbiter #(
    .NREQ(NREQ), .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH(TW), .GRANT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cli_abtr_reqcyc(cli_abtr_reqcyc),
    .cli_bus_busy(cli_bus_busy),
    .cli_abtr_grant(cli_abtr_grant),
    .cli_bus_reqcyc(cli_bus_reqcyc),
    .cli_bus_req(cli_bus_req),
    .cli_bus_reqtag(cli_bus_reqtag),
    .cli_bus_respack(cli_bus_respack),
    .cli_bus_reqack(cli_bus_reqack),
    .cli_bus_respcyc(cli_bus_respcyc),
    .cli_bus_resp(cli_bus_resp),
    .cli_bus_resptag(cli_bus_resptag),
    .bus_reqcyc(bus_reqcyc),
    .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_respack(bus_respack),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp),
    .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] DC = 64'h5555_6666_7777_8888;
  localparam logic [12:0] TA = 13'h0A1;
  localparam logic [12:0] TB = 13'h1B2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    cli_abtr_reqcyc = '0;
    cli_bus_busy    = '0;
    cli_bus_reqcyc  = '0;
    cli_bus_req     = '0;
    cli_bus_reqtag  = '0;
    cli_bus_respack = '0;
    bus_reqack      = 1'b0;
    bus_respcyc     = 1'b0;
    bus_resp        = '0;
    bus_resptag     = '0;

    // reset state
    push("rst_grant", 64'(2'b00));
    push("rst_reqcyc", 64'(1'b0));
    push("rst_req", 64'h0);
    tick();
    tick();
    pop_chk(64'(cli_abtr_grant));
    pop_chk(64'(bus_reqcyc));
    pop_chk(64'(bus_req));

    // I-cache request, one cycle grant latency
    reset = 1'b0;
    cli_bus_req     = {DB, DA};
    cli_bus_reqtag  = {TB, TA};
    cli_bus_reqcyc  = 2'b11;
    cli_bus_respack = 2'b11;
    cli_abtr_reqcyc = 2'b01;
    push("t1_nolat", 64'(2'b00));
    #1 pop_chk(64'(cli_abtr_grant));
    push("t1_grant", 64'(2'b01));
    push("t1_req", DA);
    push("t1_tag", 64'(TA));
    push("t1_reqcyc", 64'(1'b1));
    tick();
    pop_chk(64'(cli_abtr_grant));
    pop_chk(bus_req);
    pop_chk(64'(bus_reqtag));
    pop_chk(64'(bus_reqcyc));

    // D-cache inputs have no effect
    cli_bus_req[DW +: DW] = DC;
    cli_bus_reqcyc = 2'b10;
    bus_reqack = 1'b1;
    push("t1_nonown_req", DA);
    push("t1_nonown_cyc", 64'(1'b0));
    push("t1_reqack", 64'(2'b01));
    #1;
    pop_chk(bus_req);
    pop_chk(64'(bus_reqcyc));
    pop_chk(64'(cli_bus_reqack));
    cli_bus_reqcyc = 2'b11;

    cli_bus_busy = 2'b01;
    tick();
    bus_reqack = 1'b0;
    cli_abtr_reqcyc = 2'b00;
    cli_bus_busy = 2'b00;
    push("t1_release", 64'(2'b00));
    push("t1_rel_req", 64'h0);
    tick();
    pop_chk(64'(cli_abtr_grant));
    pop_chk(bus_req);

    // simultaneous requests after reset: requester 0 first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cli_abtr_reqcyc = 2'b11;
    push("t2_grant0", 64'(2'b01));
    tick();
    pop_chk(64'(cli_abtr_grant));
    cli_bus_busy = 2'b01;
    tick();
    cli_bus_busy = 2'b00;
    cli_abtr_reqcyc = 2'b10;
    push("t2_m1", 64'(2'b00));
    push("t2_m2", 64'(2'b10));
    tick();
    pop_chk(64'(cli_abtr_grant));
    tick();
    pop_chk(64'(cli_abtr_grant));

    // requester 1 holds bus for 20 cycles, no timeout in OWNED
    cli_bus_busy = 2'b10;
    cli_abtr_reqcyc = 2'b11;
    for (int i = 0; i < 20; i++) begin
      push("t3_hold", 64'(2'b10));
      tick();
      pop_chk(64'(cli_abtr_grant));
    end

    // response routed to owner 1
    bus_respcyc = 1'b1;
    bus_resp    = 64'hDEAD_BEEF;
    bus_resptag = 13'h1A5;
    cli_bus_respack = 2'b10;
    push("t5_respcyc", 64'(2'b10));
    push("t5_resp", 64'hDEAD_BEEF);
    push("t5_tag", 64'h1A5);
    push("t5_respack", 64'(1'b1));
    #1;
    pop_chk(64'(cli_bus_respcyc));
    pop_chk(cli_bus_resp);
    pop_chk(64'(cli_bus_resptag));
    pop_chk(64'(bus_respack));
    cli_bus_respack = 2'b01;
    push("t5_nonown_ack", 64'(1'b0));
    #1 pop_chk(64'(bus_respack));
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;

    // release to requester 0, which never asserts busy
    cli_bus_busy = 2'b00;
    cli_abtr_reqcyc = 2'b01;
    push("t4_turn", 64'(2'b00));
    push("t4_g0", 64'(2'b01));
    tick();
    pop_chk(64'(cli_abtr_grant));
    tick();
    pop_chk(64'(cli_abtr_grant));
    cli_abtr_reqcyc = 2'b11;
    for (int i = 0; i < TO - 1; i++) begin
      push("t4_held", 64'(2'b01));
      tick();
      pop_chk(64'(cli_abtr_grant));
    end
    push("t4_revoked", 64'(2'b00));
    push("t4_next", 64'(2'b10));
    tick();
    pop_chk(64'(cli_abtr_grant));
    tick();
    pop_chk(64'(cli_abtr_grant));

    // hand back to requester 0, then reset while it owns
    cli_abtr_reqcyc = 2'b01;
    push("t6_turn", 64'(2'b00));
    push("t6_g0", 64'(2'b01));
    tick();
    pop_chk(64'(cli_abtr_grant));
    tick();
    pop_chk(64'(cli_abtr_grant));
    cli_bus_busy = 2'b01;
    push("t6_own", 64'(2'b01));
    push("t6_own_cyc", 64'(1'b1));
    push("t6_own_req", DA);
    tick();
    pop_chk(64'(cli_abtr_grant));
    pop_chk(64'(bus_reqcyc));
    pop_chk(bus_req);
    reset = 1'b1;
    push("t6_rst_grant", 64'(2'b00));
    push("t6_rst_cyc", 64'(1'b0));
    push("t6_rst_req", 64'h0);
    push("t6_rst_tag", 64'h0);
    push("t6_rst_ack", 64'(1'b0));
    tick();
    pop_chk(64'(cli_abtr_grant));
    pop_chk(64'(bus_reqcyc));
    pop_chk(bus_req);
    pop_chk(64'(bus_reqtag));
    pop_chk(64'(bus_respack));
    reset = 1'b0;
    cli_bus_busy = 2'b00;
    cli_abtr_reqcyc = 2'b11;
    push("t6_ptr0", 64'(2'b01));
    tick();
    pop_chk(64'(cli_abtr_grant));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0",
             sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
